// File: rtl/alu_ctrl_muldiv_pkg.sv
// Shared ALU definitions: ALU_control codes, ALUOp and funct codes, multiply/divide FSM states.
// Consumed by alu_ctrl_muldiv and the main ALU.
package alu_ctrl_muldiv_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ALT   = 2'b11;

    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    // ALUOp/funct to ALU operation select; unknown functs fall back to add
    function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [3:0] ctrl;
        ctrl = ALU_ADD;
        case (aluop)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_ALT: ctrl = ALU_ADD;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_AND:              ctrl = ALU_AND;
                    FUNCT_OR:               ctrl = ALU_OR;
                    FUNCT_ADD, FUNCT_ADDU:  ctrl = ALU_ADD;
                    FUNCT_SUB, FUNCT_SUBU:  ctrl = ALU_SUB;
                    FUNCT_SLT, FUNCT_SLTU:  ctrl = ALU_SLT;
                    FUNCT_NOR:              ctrl = ALU_NOR;
                    default:                ctrl = ALU_ADD;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/alu_ctrl_muldiv_core.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide, sign fix-up.
// MULDIV_EARLY_TERM_EN: multiplies finish once the remaining multiplier bits are zero.
module alu_ctrl_muldiv_core
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             step,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish_c,
    output logic [WIDTH-1:0] res_hi_c,
    output logic [WIDTH-1:0] res_lo_c,
    output logic             res_dbz_c
);

    localparam int unsigned W2 = 2 * WIDTH;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [W2-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]   rem_sh;
    logic [W2-1:0]    p_fix;
    logic             early_c;

    // For divide, mplier holds the dividend shifting into the quotient and acc[WIDTH-1:0] the remainder
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dbz_d     = dbz_q;
        a_mag     = (op_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        rem_sh    = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
        if (load) begin
            cnt_d     = '0;
            acc_d     = '0;
            div_d     = op_div;
            neg_res_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = op_signed && op_div && a[WIDTH-1];
            dbz_d     = op_div && (b == '0);
            mplier_d  = op_div ? a_mag : b_mag;
            mcand_d   = {WIDTH'(0), (op_div ? b_mag : a_mag)};
        end else if (step) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_q) begin
                if (rem_sh >= {1'b0, mcand_q[WIDTH-1:0]}) begin
                    acc_d    = {WIDTH'(0), WIDTH'(rem_sh - {1'b0, mcand_q[WIDTH-1:0]})};
                    mplier_d = {mplier_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d    = {WIDTH'(0), rem_sh[WIDTH-1:0]};
                    mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
            end
        end
    end

    always_comb begin
`ifdef MULDIV_EARLY_TERM_EN
        early_c = !div_q && (mplier_q == '0);
`else
        early_c = 1'b0;
`endif
        q_fix     = neg_res_q ? (~mplier_q + WIDTH'(1)) : mplier_q;
        r_fix     = neg_rem_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
        p_fix     = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
        finish_c  = (cnt_q == CNT_W'(WIDTH)) || early_c;
        res_dbz_c = dbz_q;
        if (div_q) begin
            res_hi_c = r_fix;
            res_lo_c = dbz_q ? '1 : q_fix;
        end else begin
            res_hi_c = p_fix[W2-1:WIDTH];
            res_lo_c = p_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dbz_q     <= dbz_d;
        end
    end

endmodule

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU control with iterative multiply/divide owning HI/LO and a stall request while busy.
// MULDIV_EARLY_TERM_EN (optional): shortens multiplies whose remaining multiplier bits are zero.
module alu_ctrl_muldiv
    import alu_ctrl_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       funct,
    input  logic             start,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       ALU_control,
    output logic             md_busy,
    output logic             md_done,
    output logic             md_stall,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic             md_op_c, move_op_c, read_op_c, accept_c, step_c;
    logic             op_div_c, op_signed_c, finish_c, res_dbz_c;
    logic [WIDTH-1:0] res_hi_c, res_lo_c;

    always_comb begin
        md_op_c     = (ALUOp == ALUOP_RTYPE) &&
                      (funct == FUNCT_MULT || funct == FUNCT_MULTU ||
                       funct == FUNCT_DIV  || funct == FUNCT_DIVU);
        move_op_c   = (ALUOp == ALUOP_RTYPE) && (funct == FUNCT_MTHI || funct == FUNCT_MTLO);
        read_op_c   = (ALUOp == ALUOP_RTYPE) && (funct == FUNCT_MFHI || funct == FUNCT_MFLO);
        op_div_c    = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
        op_signed_c = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
        accept_c    = start && md_op_c && (state_q != ST_CALC);
        step_c      = (state_q == ST_CALC) && !finish_c;
    end

    alu_ctrl_muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept_c),
        .step      (step_c),
        .op_div    (op_div_c),
        .op_signed (op_signed_c),
        .a         (rs_val),
        .b         (rt_val),
        .finish_c  (finish_c),
        .res_hi_c  (res_hi_c),
        .res_lo_c  (res_lo_c),
        .res_dbz_c (res_dbz_c)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept_c) state_d = ST_CALC;
            ST_CALC: if (finish_c) state_d = ST_DONE;
            ST_DONE: state_d = accept_c ? ST_CALC : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Result lands on the edge leaving CALC; moves only happen outside CALC and win over it
    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        dbz_d = dbz_q;
        if (state_q == ST_CALC && finish_c) begin
            hi_d  = res_hi_c;
            lo_d  = res_lo_c;
            dbz_d = res_dbz_c;
        end
        if (start && move_op_c && state_q != ST_CALC) begin
            if (funct == FUNCT_MTHI) hi_d = rs_val;
            else                     lo_d = rs_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            dbz_q <= dbz_d;
        end
    end

    always_comb begin
        ALU_control = alu_decode(ALUOp, funct);
        md_busy     = (state_q == ST_CALC);
        md_done     = (state_q == ST_DONE);
        md_stall    = start && (state_q == ST_CALC) && (md_op_c || move_op_c || read_op_c);
        div_by_zero = dbz_q;
        hi          = hi_q;
        lo          = lo_q;
    end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Self-checking bench for alu_ctrl_muldiv: decode table, multiply/divide results and latency, stall, reset.
module tb_alu_ctrl_muldiv;

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  ALUOp;
    logic [5:0]  funct;
    logic        start;
    logic [31:0] rs_val, rt_val;
    logic [3:0]  ALU_control;
    logic        md_busy, md_done, md_stall, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_muldiv dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ALUOp       (ALUOp),
        .funct       (funct),
        .start       (start),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .ALU_control (ALU_control),
        .md_busy     (md_busy),
        .md_done     (md_done),
        .md_stall    (md_stall),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ALUOp  = 2'b10;
        funct  = f;
        rs_val = a;
        rt_val = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (md_done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    function automatic bit mul_lat_ok(input int n);
`ifdef MULDIV_EARLY_TERM_EN
        return (n >= 1 && n <= 33);
`else
        return (n == 33);
`endif
    endfunction

    function automatic logic [3:0] exp_ctrl(input logic [1:0] aluop, input logic [5:0] f);
        if (aluop == 2'b01) return 4'b0110;
        if (aluop != 2'b10) return 4'b0010;
        case (f)
            6'b100100:            return 4'b0000;
            6'b100101:            return 4'b0001;
            6'b100010, 6'b100011: return 4'b0110;
            6'b101010, 6'b101011: return 4'b0111;
            6'b100111:            return 4'b1100;
            default:              return 4'b0010;
        endcase
    endfunction

    // Architectural HI/LO outcome computed with native wide arithmetic
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el, output logic edbz);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = a;
        sb = b;
        edbz = 1'b0;
        eh = '0;
        el = '0;
        if (f == F_MULT) begin
            sp = longint'(sa) * longint'(sb);
            {eh, el} = sp;
        end else if (f == F_MULTU) begin
            up = {32'b0, a} * {32'b0, b};
            {eh, el} = up;
        end else if (b == 32'd0) begin
            el = 32'hFFFF_FFFF;
            eh = a;
            edbz = 1'b1;
        end else if (f == F_DIV) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                el = 32'h8000_0000;
                eh = 32'h0;
            end else begin
                el = sa / sb;
                eh = sa % sb;
            end
        end else begin
            el = a / b;
            eh = a % b;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", md_busy); end
        checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", md_done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi, lo); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [1:0] ops[5]  = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [5:0] fns[5]  = '{6'b100101, 6'b011011, 6'b100111, 6'b111111, 6'b100010};
        logic [3:0] exps[5] = '{4'b0001, 4'b0110, 4'b1100, 4'b0010, 4'b0010};
        logic [5:0] known[9] = '{6'b100100, 6'b100101, 6'b100000, 6'b100001, 6'b100010,
                                 6'b100011, 6'b101010, 6'b101011, 6'b100111};
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ALUOp = ops[i];
            funct = fns[i];
            #1;
            checks++;
            if (ALU_control !== exps[i]) begin
                errors++;
                $display("FAIL decode_dir aluop=%b funct=%b got=%b exp=%b", ALUOp, funct, ALU_control, exps[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            ALUOp = 2'($urandom_range(0, 3));
            funct = ($urandom_range(0, 1) == 1) ? known[$urandom_range(0, 8)] : 6'($urandom_range(0, 63));
            #1;
            checks++;
            if (ALU_control !== exp_ctrl(ALUOp, funct)) begin
                errors++;
                $display("FAIL decode_rand aluop=%b funct=%b got=%b exp=%b", ALUOp, funct, ALU_control,
                         exp_ctrl(ALUOp, funct));
            end
        end
        tick();
    endtask

    task automatic test_mult();
        logic [5:0]  fs[2]  = '{F_MULT, F_MULTU};
        logic [31:0] ehs[2] = '{32'hFFFF_FFFF, 32'h0000_0006};
        int n;
        for (int i = 0; i < 2; i++) begin
            issue(fs[i], 32'hFFFF_FFFD, 32'h7);
            wait_done(n);
            checks++; if (!mul_lat_ok(n)) begin errors++; $display("FAIL mult_latency op=%b got=%0d exp=33", fs[i], n); end
            checks++; if (hi !== ehs[i]) begin errors++; $display("FAIL mult_hi op=%b got=%h exp=%h", fs[i], hi, ehs[i]); end
            checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo op=%b got=%h exp=ffffffeb", fs[i], lo); end
            tick();
            checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL done_pulse got=%b exp=0", md_done); end
        end
    endtask

    task automatic test_div();
        logic [5:0]  fs[5]  = '{F_DIVU, F_DIV, F_DIV, F_DIV, F_DIVU};
        logic [31:0] as[5]  = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'd6};
        logic [31:0] bs[5]  = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd3};
        logic [31:0] els[5] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] ehs[5] = '{32'd2, 32'hFFFF_FFFF, 32'h0, 32'd5, 32'd0};
        logic        eds[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int n;
        for (int i = 0; i < 5; i++) begin
            issue(fs[i], as[i], bs[i]);
            wait_done(n);
            checks++; if (n != 33) begin errors++; $display("FAIL div_latency case=%0d got=%0d exp=33", i, n); end
            checks++; if (lo !== els[i]) begin errors++; $display("FAIL div_lo case=%0d got=%h exp=%h", i, lo, els[i]); end
            checks++; if (hi !== ehs[i]) begin errors++; $display("FAIL div_hi case=%0d got=%h exp=%h", i, hi, ehs[i]); end
            checks++; if (div_by_zero !== eds[i]) begin errors++; $display("FAIL div_dbz case=%0d got=%b exp=%b", i, div_by_zero, eds[i]); end
            tick();
        end
    endtask

    task automatic test_random_md();
        logic [5:0]  ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        logic [5:0]  f;
        logic [31:0] a, b, eh, el;
        logic        ed;
        int n;
        for (int i = 0; i < 24; i++) begin
            f = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'($urandom_range(0, 1000));
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            model(f, a, b, eh, el, ed);
            issue(f, a, b);
            wait_done(n);
            checks++;
            if (hi !== eh || lo !== el || div_by_zero !== ed) begin
                errors++;
                $display("FAIL rand_md op=%b a=%h b=%h got=%h_%h/%b exp=%h_%h/%b", f, a, b, hi, lo, div_by_zero, eh, el, ed);
            end
            checks++;
            if ((f == F_DIV || f == F_DIVU) ? (n != 33) : !mul_lat_ok(n)) begin
                errors++;
                $display("FAIL rand_latency op=%b got=%0d", f, n);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, eh, el;
        logic        ed;
        int n;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'h1;
        issue(F_MULT, a1, b1);
        wait_done(n);
        model(F_MULT, a1, b1, eh, el, ed);
        checks++; if (hi !== eh || lo !== el) begin errors++; $display("FAIL b2b_first got=%h_%h exp=%h_%h", hi, lo, eh, el); end
        issue(F_DIVU, a2, b2);
        checks++; if (md_busy !== 1'b1 || md_done !== 1'b0) begin errors++; $display("FAIL b2b_accept busy=%b done=%b exp=1/0", md_busy, md_done); end
        wait_done(n);
        model(F_DIVU, a2, b2, eh, el, ed);
        checks++; if (n != 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", n); end
        checks++; if (hi !== eh || lo !== el) begin errors++; $display("FAIL b2b_second got=%h_%h exp=%h_%h", hi, lo, eh, el); end
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] a, b, x, y, eh, el;
        logic        ed;
        int n;
        a = $urandom; b = $urandom | 32'h1;
        issue(F_DIVU, a, b);
        funct = F_MFLO;
        start = 1'b1;
        for (int k = 0; k < 33; k++) begin
            checks++;
            if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_mflo cycle=%0d got=%b exp=1", k, md_stall); end
            tick();
        end
        checks++; if (md_done !== 1'b1 || md_stall !== 1'b0) begin errors++; $display("FAIL stall_done done=%b stall=%b exp=1/0", md_done, md_stall); end
        start = 1'b0;
        tick();
        a = $urandom; b = $urandom | 32'h1;
        model(F_DIVU, a, b, eh, el, ed);
        issue(F_DIVU, a, b);
        funct  = F_MTHI;
        rs_val = 32'hDEAD_BEEF;
        start  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (md_stall !== 1'b1) begin errors++; $display("FAIL stall_mthi cycle=%0d got=%b exp=1", k, md_stall); end
            tick();
        end
        start = 1'b0;
        wait_done(n);
        checks++; if (hi !== eh || lo !== el) begin errors++; $display("FAIL stall_result got=%h_%h exp=%h_%h", hi, lo, eh, el); end
        tick();
        x = $urandom; y = $urandom;
        ALUOp = 2'b10; funct = F_MTHI; rs_val = x; start = 1'b1;
        tick();
        funct = F_MTLO; rs_val = y;
        tick();
        start = 1'b0;
        checks++; if (hi !== x || lo !== y) begin errors++; $display("FAIL mthi_mtlo got=%h/%h exp=%h/%h", hi, lo, x, y); end
        checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL move_busy got=%b exp=0", md_busy); end
    endtask

    task automatic test_reset_mid();
        int n;
        int spurious;
        issue(F_MULTU, $urandom | 32'h1, 32'hFFFF_FFFF);
        for (int k = 1; k < 10; k++) tick();
        reset_n = 1'b0;
        tick();
        checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin errors++; $display("FAIL midreset_state busy=%b done=%b exp=0/0", md_busy, md_done); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midreset_hilo got=%h/%h exp=0/0", hi, lo); end
        reset_n = 1'b1;
        spurious = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (md_done === 1'b1) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL midreset_done got=%0d exp=0", spurious); end
        issue(F_MULTU, 32'd2, 32'd3);
        wait_done(n);
        checks++; if (lo !== 32'd6 || hi !== 32'd0) begin errors++; $display("FAIL post_reset_mul got=%h_%h exp=0_6", hi, lo); end
        checks++; if (!mul_lat_ok(n)) begin errors++; $display("FAIL post_reset_latency got=%0d", n); end
        tick();
`ifdef MULDIV_EARLY_TERM_EN
        issue(F_MULTU, 32'd5, 32'd1);
        wait_done(n);
        checks++; if (n > 2) begin errors++; $display("FAIL early_latency got=%0d exp<=2", n); end
        checks++; if (lo !== 32'd5 || hi !== 32'd0) begin errors++; $display("FAIL early_result got=%h_%h exp=0_5", hi, lo); end
        tick();
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        ALUOp   = 2'b00;
        funct   = 6'b0;
        rs_val  = '0;
        rt_val  = '0;
        test_reset();
        test_decode();
        test_mult();
        test_div();
        test_random_md();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
